fetch_sequencer: RTL and testbench

Instruction-fetch controller placed between the program RAM and the processor core. Steps a program counter through a synchronous-read RAM, delivers each instruction word (and the immediate word of two-word instructions) on the core's `DIN`, pulses `Run`, and waits for `Done` before fetching the next instruction. A watchdog flags a core that never signals `Done`. With this block, the board top runs a stored program without manual `DIN` switching.

---
 rtl/fetch_seq_pkg.sv | 30 +++
 rtl/done_watchdog.sv | 29 ++
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared state encoding and opcode field layout for the fetch sequencer.
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_LATCH_IMM,
      S_ISSUE,
      S_IMM,
      S_EXEC,
      S_ERROR
   } fstate_t;

   localparam int OPC_HI = 8;
   localparam int OPC_LO = 6;
   localparam int OPC_W  = OPC_HI - OPC_LO + 1;

   typedef logic [OPC_W-1:0] opc_t;

   localparam opc_t MVI_OPC_DEF = 3'b001;

   function automatic logic is_two_word(
      input opc_t opc,
      input opc_t mvi
   );
      return opc == mvi;
   endfunction

endpackage

// File: rtl/done_watchdog.sv
// Cycle counter bounding how long the core may take to answer Done.
module done_watchdog
   import fetch_seq_pkg::*;
#(
   parameter int unsigned LIMIT = 15
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   // Flags the cycle whose increment makes the count reach LIMIT.
   assign expired = en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: RAM -> core DIN with Run/Done handshake.
// Optional single-step push-button input under FETCH_SINGLE_STEP_EN.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int   ADDR_W  = 5,
   parameter int   DATA_W  = 16,
   parameter opc_t MVI_OPC = MVI_OPC_DEF,
   parameter int   TIMEOUT = 15
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Enable,
`ifdef FETCH_SINGLE_STEP_EN
   input  logic              Step,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   input  logic              Done,
   output logic [ADDR_W-1:0] pc,
   output logic              Busy,
   output logic              Error
);

   fstate_t           state;
   logic [DATA_W-1:0] ibuf;
   logic [DATA_W-1:0] imm;
   logic              two;
   logic              mvi_now;
   logic              tok_ok;
   logic              go;
   logic              wd_expired;

   assign mvi_now = is_two_word(mem_q[OPC_HI:OPC_LO], MVI_OPC);

`ifdef FETCH_SINGLE_STEP_EN
   logic [2:0] step_sync;
   logic       step_tok;

   // Two sync flops, then one more for the rising-edge detect.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step_sync <= '0;
         step_tok  <= 1'b0;
      end else begin
         step_sync <= {step_sync[1:0], Step};
         step_tok  <= (step_tok & ~go)
                    | (step_sync[1] & ~step_sync[2]);
      end
   end

   assign tok_ok = step_tok;
`else
   assign tok_ok = 1'b1;
`endif

   assign go = Enable && tok_ok
            && (state == S_IDLE
            || (state == S_EXEC && Done));

   done_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_wd (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .clr     (state == S_ISSUE),
      .en      (state == S_EXEC),
      .expired (wd_expired)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state    <= S_IDLE;
         pc       <= '0;
         mem_addr <= '0;
         DIN      <= '0;
         Run      <= 1'b0;
         Busy     <= 1'b0;
         Error    <= 1'b0;
         ibuf     <= '0;
         imm      <= '0;
         two      <= 1'b0;
      end else begin
         Run <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  state    <= S_FETCH;
                  mem_addr <= pc;
                  Busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               // Immediate address is presented early; harmless
               // for single-word instructions.
               state    <= S_LATCH;
               mem_addr <= pc + ADDR_W'(1);
            end
            S_LATCH: begin
               ibuf <= mem_q;
               two  <= mvi_now;
               if (mvi_now) begin
                  state <= S_LATCH_IMM;
               end else begin
                  state <= S_ISSUE;
                  DIN   <= mem_q;
                  Run   <= 1'b1;
               end
            end
            S_LATCH_IMM: begin
               imm   <= mem_q;
               state <= S_ISSUE;
               DIN   <= ibuf;
               Run   <= 1'b1;
            end
            S_ISSUE: begin
               if (two) begin
                  state <= S_IMM;
                  DIN   <= imm;
               end else begin
                  state <= S_EXEC;
                  pc    <= pc + ADDR_W'(1);
               end
            end
            S_IMM: begin
               state <= S_EXEC;
               pc    <= pc + ADDR_W'(2);
            end
            S_EXEC: begin
               if (Done) begin
                  if (go) begin
                     state    <= S_FETCH;
                     mem_addr <= pc;
                  end else begin
                     state <= S_IDLE;
                     Busy  <= 1'b0;
                  end
               end else if (wd_expired) begin
                  state <= S_ERROR;
                  Busy  <= 1'b0;
                  Error <= 1'b1;
               end
            end
            S_ERROR: begin
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: RAM and core models with an issue scoreboard.
module tb_fetch_sequencer;

   typedef struct {
      logic [4:0]  addr;
      logic [15:0] word;
      logic [15:0] immw;
      logic        two;
      logic [4:0]  pc_after;
   } vec_t;

   logic        Clock  = 1'b0;
   logic        Resetn = 1'b0;
   logic        Enable = 1'b0;
   logic [4:0]  mem_addr;
   logic [15:0] mem_q  = '0;
   logic [15:0] DIN;
   logic        Run;
   logic        Done   = 1'b0;
   logic [4:0]  pc;
   logic        Busy;
   logic        Error;
`ifdef FETCH_SINGLE_STEP_EN
   logic        Step   = 1'b0;
`endif

   logic [15:0] ram [0:31];
   vec_t        tbl [30];
   vec_t        sbq [$];
   vec_t        cur;
   logic [4:0]  hist [0:3];
   logic [4:0]  na;
   int checks   = 0;
   int failures = 0;
   int runs     = 0;
   int cyc      = 0;
   int last_run = 0;
   int ph       = 0;
   int done_dly = 2;
   int wait_cnt = 0;

   fetch_sequencer dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Enable   (Enable),
`ifdef FETCH_SINGLE_STEP_EN
      .Step     (Step),
`endif
      .mem_addr (mem_addr),
      .mem_q    (mem_q),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .pc       (pc),
      .Busy     (Busy),
      .Error    (Error)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      cyc   <= cyc + 1;
      mem_q <= ram[mem_addr];
   end

   function automatic void chk(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endfunction

   // Core model: Done pulses done_dly cycles after Run (0 = never).
   always @(negedge Clock) begin
      Done = 1'b0;
      if (!Resetn) begin
         wait_cnt = 0;
      end else if (Run) begin
         wait_cnt = done_dly;
      end else if (wait_cnt > 0) begin
         wait_cnt--;
         if (wait_cnt == 0) Done = 1'b1;
      end
   end

   // Scoreboard monitor.
   always @(negedge Clock) begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = mem_addr;
      if (!Resetn) begin
         ph = 0;
      end else begin
         if (ph == 1) begin
            chk("run_width", 32'(Run), 32'd0);
            if (cur.two) begin
               chk("imm_din", 32'(DIN), 32'(cur.immw));
               ph = 2;
            end else begin
               chk("pc_after", 32'(pc), 32'(cur.pc_after));
               ph = 0;
            end
         end else if (ph == 2) begin
            chk("pc_after", 32'(pc), 32'(cur.pc_after));
            ph = 0;
         end
         if (Run) begin
            runs++;
            last_run = cyc;
            if (sbq.size() == 0) begin
               chk("run_while_queue_empty", 32'(sbq.size()), 32'd1);
            end else begin
               cur = sbq.pop_front();
               chk("issue_din", 32'(DIN), 32'(cur.word));
               chk("issue_pc", 32'(pc), 32'(cur.addr));
               if (cur.two) begin
                  na = cur.addr + 5'd1;
                  chk("fetch_addr", 32'(hist[3]), 32'(cur.addr));
                  chk("imm_addr", 32'(hist[2]), 32'(na));
               end else begin
                  chk("fetch_addr", 32'(hist[2]), 32'(cur.addr));
               end
               ph = 1;
            end
         end
      end
   end

   task automatic load_ram();
      logic [4:0] a1;
      for (int i = 0; i < 32; i++) ram[i] = '0;
      foreach (tbl[i]) begin
         ram[tbl[i].addr] = tbl[i].word;
         if (tbl[i].two) begin
            a1 = tbl[i].addr + 5'd1;
            ram[a1] = tbl[i].immw;
         end
      end
   endtask

   task automatic reset_dut();
      Enable = 1'b0;
      Resetn = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
      Step = 1'b0;
`endif
      sbq.delete();
      repeat (2) @(negedge Clock);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_din", 32'(DIN), 32'd0);
      chk("rst_run", 32'(Run), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_error", 32'(Error), 32'd0);
      Resetn = 1'b1;
   endtask

   task automatic wait_runs(input int n, input int budget,
                            input string name);
      int k = 0;
      while (runs < n && k < budget) begin
         @(negedge Clock);
         k++;
      end
      chk(name, 32'(runs >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (Busy !== 1'b0 && k < budget) begin
         @(negedge Clock);
         k++;
      end
      chk(name, 32'(Busy), 32'd0);
   endtask

   task automatic wait_pc(input logic [4:0] v, input int budget,
                          input string name);
      int k = 0;
      while (pc !== v && k < budget) begin
         @(negedge Clock);
         k++;
      end
      chk(name, 32'(pc), 32'(v));
   endtask

`ifdef FETCH_SINGLE_STEP_EN
   task automatic press();
      Step = 1'b1;
      repeat (4) @(negedge Clock);
      Step = 1'b0;
      repeat (2) @(negedge Clock);
   endtask
`endif

   initial begin
      int base;
      int r;
      int c0;
      int k;
      tbl[0]  = '{5'd0,  16'h0080, 16'h0000, 1'b0, 5'd1};
      tbl[1]  = '{5'd1,  16'h0040, 16'h1234, 1'b1, 5'd3};
      tbl[2]  = '{5'd3,  16'h01C0, 16'h0000, 1'b0, 5'd4};
      tbl[3]  = '{5'd4,  16'h0000, 16'h0000, 1'b0, 5'd5};
      tbl[4]  = '{5'd5,  16'hFE7F, 16'hBEEF, 1'b1, 5'd7};
      for (int a = 7; a <= 30; a++)
         tbl[a-2] = '{5'(a), 16'hA000 | 16'(a), 16'h0000,
                      1'b0, 5'(a + 1)};
      tbl[29] = '{5'd31, 16'h0240, 16'h0080, 1'b1, 5'd1};
      load_ram();
      reset_dut();
      base = 0;
      r = 0;
      k = 0;

`ifdef FETCH_SINGLE_STEP_EN
      done_dly = 2;
      Enable = 1'b1;
      for (int p = 0; p < 3; p++) begin
         sbq.push_back(tbl[p]);
         press();
         wait_runs(p + 1, 30, "step_run_timeout");
         wait_idle(30, "step_idle_timeout");
         repeat (6) @(negedge Clock);
         chk("step_busy_between", 32'(Busy), 32'd0);
         chk("step_run_count", 32'(runs), 32'(p + 1));
      end
      done_dly = 10;
      sbq.push_back(tbl[3]);
      sbq.push_back(tbl[4]);
      press();
      wait_runs(4, 30, "step_exec_run_timeout");
      press();
      wait_runs(5, 40, "step_extra_run_timeout");
      wait_idle(60, "step_extra_idle_timeout");
      repeat (20) @(negedge Clock);
      chk("step_double_runs", 32'(runs), 32'd5);
      chk("step_double_pc", 32'(pc), 32'd7);
      chk("step_double_busy", 32'(Busy), 32'd0);
`else
      // Whole program run, ending with the wrapping MVI at 31.
      done_dly = 2;
      foreach (tbl[i]) sbq.push_back(tbl[i]);
      @(negedge Clock);
      Enable = 1'b1;
      c0 = cyc;
      @(negedge Clock);
      chk("fetch_busy", 32'(Busy), 32'd1);
      chk("fetch_mem_addr", 32'(mem_addr), 32'd0);
      chk("fetch_no_run", 32'(Run), 32'd0);
      wait_runs(1, 10, "first_run_timeout");
      chk("first_run_latency", 32'(last_run - c0), 32'd3);
      while (sbq.size() != 0 && k < 1000) begin
         @(negedge Clock);
         k++;
      end
      chk("program_drain", 32'(sbq.size()), 32'd0);
      Enable = 1'b0;
      wait_idle(40, "t1_idle_timeout");
      repeat (4) @(negedge Clock);
      chk("t1_runs", 32'(runs), 32'd30);
      chk("t1_pc_wrap", 32'(pc), 32'd1);

      // Enable dropped during EXEC of a two-word instruction.
      base = runs;
      done_dly = 3;
      sbq.push_back(tbl[1]);
      Enable = 1'b1;
      wait_runs(base + 1, 20, "t2_run_timeout");
      wait_pc(5'd3, 10, "t2_exec_pc");
      Enable = 1'b0;
      repeat (12) @(negedge Clock);
      chk("t2_idle_busy", 32'(Busy), 32'd0);
      chk("t2_no_extra_run", 32'(runs), 32'(base + 1));
      chk("t2_pc", 32'(pc), 32'd3);
      sbq.push_back(tbl[2]);
      Enable = 1'b1;
      wait_runs(base + 2, 20, "t2_resume_timeout");
      Enable = 1'b0;
      wait_idle(20, "t2_resume_idle_timeout");
      repeat (2) @(negedge Clock);
      chk("t2_resume_pc", 32'(pc), 32'd4);

      // Core never answers: watchdog trip, then async reset.
      base = runs;
      done_dly = 0;
      sbq.push_back(tbl[3]);
      Enable = 1'b1;
      wait_runs(base + 1, 20, "t3_run_timeout");
      r = last_run;
      while (cyc < r + 15) @(negedge Clock);
      chk("wd_no_error_early", 32'(Error), 32'd0);
      chk("wd_busy_before", 32'(Busy), 32'd1);
      @(negedge Clock);
      chk("wd_error_set", 32'(Error), 32'd1);
      chk("wd_busy_after", 32'(Busy), 32'd0);
      repeat (8) @(negedge Clock);
      chk("wd_error_sticky", 32'(Error), 32'd1);
      chk("wd_no_run", 32'(runs), 32'(base + 1));
      Enable = 1'b0;
      #3 Resetn = 1'b0;
      #1;
      chk("async_rst_error", 32'(Error), 32'd0);
      chk("async_rst_pc", 32'(pc), 32'd0);
      chk("async_rst_busy", 32'(Busy), 32'd0);
      @(negedge Clock);
      Resetn = 1'b1;
      repeat (2) @(negedge Clock);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "simulation time limit");
   end

endmodule
